// File: rtl/pipe_mem_arbiter.sv
// Shares one single-port, fixed-latency memory between the IF and DM pipeline stages.
// DM has priority; a DM-grant streak limit guarantees IF forward progress.
module pipe_mem_arbiter #(
    parameter int unsigned LAT        = 2,
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned AW         = 32
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [31:0]   if_rdata,
    output logic          if_stall,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic          dm_ack,
    output logic [31:0]   dm_rdata,
    output logic          dm_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    localparam logic [3:0] LAT_V = 4'(LAT);
    localparam logic [3:0] MAX_V = 4'(MAX_STREAK);

    state_t     state;
    owner_t     last;
    logic [3:0] lat_cnt;
    logic [3:0] streak;
    logic       elig_if, elig_dm, grant_if, grant_dm;

    // In DONE the just-served requester still holds req during its ack cycle, so only the other one may win.
    always_comb begin
        elig_if = 1'b0;
        elig_dm = 1'b0;
        if (state == IDLE) begin
            elig_if = if_req;
            elig_dm = dm_req;
        end else if (state == DONE) begin
            elig_if = if_req && (last == OWN_DM);
            elig_dm = dm_req && (last == OWN_IF);
        end
        grant_if = elig_if && (!elig_dm || (streak == MAX_V));
        grant_dm = elig_dm && !grant_if;
    end

    assign if_stall = if_req & ~if_ack;
    assign dm_stall = dm_req & ~dm_ack;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= IDLE;
            last      <= OWN_IF;
            lat_cnt   <= '0;
            streak    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            mem_en <= 1'b0;
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (grant_if || grant_dm) begin
                        state   <= BUSY;
                        lat_cnt <= LAT_V;
                        mem_en  <= 1'b1;
                        last    <= grant_if ? OWN_IF : OWN_DM;
                        mem_addr <= grant_if ? if_addr : dm_addr;
                        mem_we  <= grant_dm & dm_we;
                        if (grant_dm) begin
                            mem_wdata <= dm_wdata;
                        end
                        if (grant_dm && if_req) begin
                            streak <= (streak == MAX_V) ? streak : streak + 4'd1;
                        end else begin
                            streak <= '0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        state <= DONE;
                        if (last == OWN_IF) begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end else begin
                            dm_ack <= 1'b1;
                            if (!mem_we) begin
                                dm_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
